// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: stall encodings and controller state type shared by the pipeline controller
package pipe_ctrl_pkg;
  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_LU = 6'b000111;
  localparam logic [5:0] STALL_EX = 6'b001111;
  typedef enum logic [1:0] {RUN, LU_STALL, EX_STALL, FLUSH} state_t;
endpackage

// File: rtl/pipe_ctrl_hazard_det.sv
// pipe_ctrl_hazard_det: load-use hazard comparator between decode reads and the EX load destination
module pipe_ctrl_hazard_det (
  input  logic       id_reg1_read_i,
  input  logic       id_reg2_read_i,
  input  logic [4:0] id_reg1_addr_i,
  input  logic [4:0] id_reg2_addr_i,
  input  logic       ex_is_load_i,
  input  logic       ex_wreg_i,
  input  logic [4:0] ex_wd_i,
  output logic       lu_hit
);
  assign lu_hit = ex_is_load_i && ex_wreg_i && (ex_wd_i != 5'd0) &&
                  ((id_reg1_read_i && id_reg1_addr_i == ex_wd_i) ||
                   (id_reg2_read_i && id_reg2_addr_i == ex_wd_i));
endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: merges flush, EX busy and load-use hazards into stall/flush controls with stall statistics
module pipe_ctrl import pipe_ctrl_pkg::*; #(
  parameter int STALL_W = 6,
  parameter int TIMEOUT = 255,
  parameter int CNT_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               id_reg1_read_i,
  input  logic               id_reg2_read_i,
  input  logic [4:0]         id_reg1_addr_i,
  input  logic [4:0]         id_reg2_addr_i,
  input  logic               ex_is_load_i,
  input  logic               ex_wreg_i,
  input  logic [4:0]         ex_wd_i,
  input  logic               ex_stallreq_i,
  input  logic               flush_req_i,
  input  logic [31:0]        flush_pc_i,
  output logic [STALL_W-1:0] stall_o,
  output logic               flush_o,
  output logic [31:0]        new_pc_o,
  output logic [CNT_W-1:0]   stall_cnt_o,
  output logic               timeout_o
);
  localparam int RW = $clog2(TIMEOUT + 1);
  state_t state, state_n;
  logic lu_hit, stall_any;
  logic [RW-1:0] run;
  pipe_ctrl_hazard_det u_hd (
    .id_reg1_read_i(id_reg1_read_i),
    .id_reg2_read_i(id_reg2_read_i),
    .id_reg1_addr_i(id_reg1_addr_i),
    .id_reg2_addr_i(id_reg2_addr_i),
    .ex_is_load_i(ex_is_load_i),
    .ex_wreg_i(ex_wreg_i),
    .ex_wd_i(ex_wd_i),
    .lu_hit(lu_hit)
  );
  always_ff @(posedge clk) state <= rst ? RUN : state_n;
  // the flush cycle itself never stalls; a hazard seen in LU_STALL is the one already bubbled
  always_comb begin
    state_n = RUN;
    stall_o = STALL_W'(STALL_NONE);
    if (flush_req_i) state_n = FLUSH;
    else if (state == FLUSH) state_n = RUN;
    else if (ex_stallreq_i) begin
      state_n = EX_STALL;
      stall_o = STALL_W'(STALL_EX);
    end else if (lu_hit && state != LU_STALL) begin
      state_n = LU_STALL;
      stall_o = STALL_W'(STALL_LU);
    end
    if (rst) stall_o = '0;
  end
  assign stall_any = |stall_o;
  always_ff @(posedge clk) begin
    if (rst) begin
      flush_o <= 1'b0;
      new_pc_o <= '0;
      stall_cnt_o <= '0;
      run <= '0;
      timeout_o <= 1'b0;
    end else begin
      flush_o <= flush_req_i;
      new_pc_o <= flush_req_i ? flush_pc_i : new_pc_o;
      stall_cnt_o <= stall_cnt_o + CNT_W'(stall_any && !(&stall_cnt_o));
      run <= stall_any ? run + RW'(run != RW'(TIMEOUT)) : '0;
      timeout_o <= timeout_o | (stall_any && run >= RW'(TIMEOUT - 1));
    end
  end
endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Pipeline controller for the 5-stage core. Detects load-use hazards that the decode-stage forwarding paths (EX/MEM results) cannot cover, and merges them with multi-cycle EX stall requests and flush requests. Drives the per-stage stall vector, a one-cycle flush pulse with its redirect PC, a stall-cycle performance counter and a stall-timeout flag. Sits beside the pipeline registers; consumes decode-stage read addresses and EX-stage destination info.

Parameters:
STALL_W, 6, stall vector width: bit0 pc, bit1 if, bit2 id, bit3 ex, bit4 mem, bit5 wb
TIMEOUT, 255, consecutive stall cycles before timeout_o sets
CNT_W, 32, width of stall_cnt_o

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset (`RstEnable = 1'b1)
id_reg1_read_i  in  1  decode stage reads port 1
id_reg2_read_i  in  1  decode stage reads port 2
id_reg1_addr_i  in  5  decode read address 1
id_reg2_addr_i  in  5  decode read address 2
ex_is_load_i  in  1  instruction in EX is a load (result not available until MEM)
ex_wreg_i  in  1  EX instruction writes a register
ex_wd_i  in  5  EX destination register
ex_stallreq_i  in  1  EX multi-cycle operation busy
flush_req_i  in  1  redirect request (branch/exception)
flush_pc_i  in  32  redirect target
stall_o  out  6  per-stage hold
flush_o  out  1  clear pipeline registers
new_pc_o  out  32  redirect PC, valid when flush_o=1
stall_cnt_o  out  CNT_W  total stall cycles since reset, saturating
timeout_o  out  1  sticky stall-timeout flag

Behaviour:
- Reset (clk edge with rst=1): state RUN, stall_o=0, flush_o=0, new_pc_o=0, stall_cnt_o=0, timeout_o=0, run-length counter=0. While rst=1, stall_o is forced to 0.
- lu_hit (combinational) = ex_is_load_i & ex_wreg_i & (ex_wd_i!=0) & ((id_reg1_read_i & id_reg1_addr_i==ex_wd_i) | (id_reg2_read_i & id_reg2_addr_i==ex_wd_i)). Register 0 never hazards.
- States: RUN, LU_STALL, EX_STALL, FLUSH.
- stall_o is Mealy, valid in the same cycle as its cause. Priority: flush_req_i > ex_stallreq_i > lu_hit.
  - flush_req_i=1: stall_o=0; next state FLUSH; new_pc_o<=flush_pc_i.
  - else ex_stallreq_i=1: stall_o=6'b001111; next state EX_STALL.
  - else lu_hit=1 and state!=LU_STALL: stall_o=6'b000111 (EX receives a bubble); next state LU_STALL.
  - else: stall_o=0; next state RUN.
- LU_STALL lasts exactly one cycle. lu_hit is ignored in LU_STALL, so the same hazard never double-stalls.
- EX_STALL is held while ex_stallreq_i=1. Leave on its deassertion, with the transition evaluated by the rules above that cycle.
- FLUSH: flush_o=1 for exactly one cycle, registered one cycle after flush_req_i is sampled. stall_o=0 in that cycle. A flush_req_i sampled during FLUSH is accepted: flush_o stays high the next cycle with the new new_pc_o (back-to-back). Otherwise return to RUN.
- A flush during EX_STALL abandons the stall; EX is cleared by flush_o.
- stall_cnt_o increments each cycle stall_o!=0 and saturates at all-ones.
- Run-length counter increments while stall_o!=0 and clears when stall_o=0. When it reaches TIMEOUT, timeout_o<=1. timeout_o is sticky until rst. Stalling continues regardless.
- Reset mid-stall or mid-flush: the synchronous reset wins, and all state and outputs go to reset values on that edge.

Decomposition:
- Shared defines.v additions:
  - `StallBus (5:0)
  - stall encodings `StallNone, `StallLoadUse (6'b000111), `StallEx (6'b001111)
  - state codes for the four FSM states
  - reuse `RegAddrBus, `InstAddrBus, `RstEnable, `ZeroWord
- Sub-module hazard_det: pure combinational lu_hit comparator. Keeps the FSM file focused on sequencing and allows standalone checking.

Test Plan:
1. ex_is_load_i=1, ex_wreg_i=1, ex_wd_i=5, id_reg1_read_i=1, id_reg1_addr_i=5 -> stall_o=000111 for exactly 1 cycle, then 0; stall_cnt_o=1.
2. Same as test 1 but ex_wd_i=0, or id_reg1_read_i=0 -> stall_o stays 0.
3. ex_stallreq_i high for 10 cycles with lu_hit also high -> stall_o=001111 all 10 cycles; stall_cnt_o=10; stall_o=0 on the cycle after deassertion if lu_hit is clear.
4. flush_req_i=1, flush_pc_i=32'h0000_0100 during an EX stall -> stall_o=0 that cycle; next cycle flush_o=1, new_pc_o=32'h100; following cycle flush_o=0. Repeat with flush_req_i on 2 consecutive cycles -> flush_o high for 2 cycles with the second PC.
5. ex_stallreq_i held for 256 cycles with TIMEOUT=255 -> timeout_o rises after the 255th stall cycle and stays 1 after the stall ends; rst=1 for one cycle clears timeout_o, stall_cnt_o and flush_o.
